lpc_decode_synth: RTL
=====================

# lpc_decode_synth

LPC decoder synthesis engine: the receive-side counterpart of the LPC encode chain. Given one frame of residual samples and the frame's predictor coefficients a[1..ORDER] in external synchronous-read memories, it runs the all-pole synthesis filter y[n] = e[n] − Σ a[k]·y[n−k] with one time-multiplexed multiply-accumulate and writes the reconstructed samples to an output memory. Filter history persists across frames, so consecutive frames decode continuously.

## Interface
- ORDER, 10, predictor order; coefficient addresses 1..ORDER
- FRAME_LEN, 160, samples per frame
- DATA_W, 16, signed width of residual and output samples
- COEF_W, 16, signed coefficient width
- COEF_FRAC, 12, fractional bits of coefficients (Q3.12 at default)
- ACC_W, 40, signed accumulator width

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  frame start request, sampled only in IDLE
- clear_state  in  1  sampled with an accepted start; 1 zeroes filter history before the frame
- ready  out  1  high in IDLE
- a_raddr  out  clog2(ORDER+1)  coefficient read address
- a_rdata  in  COEF_W  coefficient data, valid one cycle after address
- e_raddr  out  clog2(FRAME_LEN)  residual read address
- e_rdata  in  DATA_W  residual data, valid one cycle after address
- y_waddr  out  clog2(FRAME_LEN)  output write address
- y_wdata  out  DATA_W  output sample
- y_we  out  1  output write strobe, one cycle per sample

## Operation
- States: IDLE, FETCH, MAC, WRITE.
- IDLE: ready=1, addresses 0, y_we=0. start=1 → FETCH with n=0; history zeroed if clear_state=1 in that cycle.
- FETCH (1 cycle): e_raddr=n, a_raddr=1.
- MAC (ORDER cycles, k=1..ORDER): a_rdata is a[k]; a_raddr=k+1 while k<ORDER, else 0. k=1: acc = (e_rdata <<< COEF_FRAC) − a[1]·h[1]. k>1: acc −= a[k]·h[k]. h[k] = y[n−k].
- WRITE (1 cycle): y_we=1, y_waddr=n, y_wdata = sat(((acc + 2^(COEF_FRAC−1)) >>> COEF_FRAC)), round-half-up, arithmetic shift, saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. History shifts: h[1]=y_wdata, h[k]=h[k−1]. n<FRAME_LEN−1 → n+1, FETCH; else IDLE.
- Products are full COEF_W+DATA_W signed, sign-extended into ACC_W; no intermediate saturation.
- History holds saturated outputs; retained across frames unless cleared by clear_state or reset.
- start while not in IDLE is ignored; clear_state ignored outside accepted start.

## Timing
- Reset values: ready=1, y_we=0, a_raddr=0, e_raddr=0, y_waddr=0, y_wdata=0, history all 0, state IDLE. Reset takes effect immediately, asynchronously, including mid-frame; no further writes after assertion.
- c0 = first cycle after start is accepted (first FETCH). ready falls at c0.
- Sample n: FETCH at c0+n(ORDER+2), MAC at c0+n(ORDER+2)+1 … +ORDER, WRITE at c0+n(ORDER+2)+ORDER+1.
- Frame: FRAME_LEN·(ORDER+2) cycles; ready=1 again at c0+FRAME_LEN·(ORDER+2). A start in that cycle is accepted (back-to-back frames, one IDLE cycle between).
- Exactly FRAME_LEN y_we pulses per frame, addresses 0..FRAME_LEN−1 ascending.

## Test plan
- All a[k]=0, e[n]=n−80 → y[n]=e[n]; y_we for n at c0+12n+11 (defaults); ready returns at c0+1920.
- a[1]=−2048 (−0.5), rest 0, clear_state=1, e[0]=1000, others 0 → y=1000, 500, 250, 125, 63, 32, 16, 8, 4, 2, 1, 1, ….
- a[1]=−4096 (−1.0), e[n]=30000 → y[0]=30000, y[1..]=32767; then e[n]=−30000 with a[1]=0 → −30000; a[1]=−4096, e=−30000 after history −30000 → −32768.
- Two frames, test 2 coefficients, second frame all e=0: clear_state=0 → second frame continues decay from first frame's last y; clear_state=1 → second frame all zeros.
- start pulsed mid-frame → no restart, write count stays FRAME_LEN; reset asserted at sample 50 → ready=1, y_we=0 at once; following start with clear_state=0 matches a fresh-from-reset run.

Source files
------------

// File: rtl/lpc_decode_synth_if.sv
// lpc_decode_synth_if -- bus bundle for the LPC synthesis engine.
//   start/clear_state/ready : frame request handshake
//   a_raddr/a_rdata         : coefficient memory (sync read, 1-cycle latency)
//   e_raddr/e_rdata         : residual memory (sync read, 1-cycle latency)
//   y_waddr/y_wdata/y_we    : reconstructed-sample write port
// slave = engine side, master = controller/memory side.
interface lpc_decode_synth_if #(
  parameter int ORDER     = 10,
  parameter int FRAME_LEN = 160,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16
);
  localparam int AAW = $clog2(ORDER + 1);
  localparam int EAW = $clog2(FRAME_LEN);

  logic              start;
  logic              clear_state;
  logic              ready;
  logic [AAW-1:0]    a_raddr;
  logic [COEF_W-1:0] a_rdata;
  logic [EAW-1:0]    e_raddr;
  logic [DATA_W-1:0] e_rdata;
  logic [EAW-1:0]    y_waddr;
  logic [DATA_W-1:0] y_wdata;
  logic              y_we;

  modport slave (
    input  start, clear_state, a_rdata, e_rdata,
    output ready, a_raddr, e_raddr, y_waddr, y_wdata, y_we
  );

  modport master (
    output start, clear_state, a_rdata, e_rdata,
    input  ready, a_raddr, e_raddr, y_waddr, y_wdata, y_we
  );
endinterface

// File: rtl/lpc_decode_synth.sv
// lpc_decode_synth -- all-pole LPC synthesis filter, y[n] = e[n] - sum a[k]*y[n-k],
// one shared MAC, one sample every ORDER+2 cycles. Filter history survives
// across frames unless clear_state accompanies an accepted start.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : lpc_decode_synth_if.slave (handshake, coef/residual reads, output writes)
module lpc_decode_synth #(
  parameter int ORDER     = 10,
  parameter int FRAME_LEN = 160,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 12,
  parameter int ACC_W     = 40
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  lpc_decode_synth_if.slave    bus
);
  localparam int AAW = $clog2(ORDER + 1);
  localparam int EAW = $clog2(FRAME_LEN);
  localparam int PW  = COEF_W + DATA_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (COEF_FRAC - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MAC, S_WRITE} state_t;

  state_t                   r_state, w_next;
  logic [EAW-1:0]           r_n;
  logic [AAW-1:0]           r_k;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_hist [ORDER];   // r_hist[i] = y[n-1-i]

  logic [AAW-1:0]           w_hidx;
  logic signed [DATA_W-1:0] w_h;
  logic signed [PW-1:0]     w_prod;
  logic signed [ACC_W-1:0]  w_prod_x, w_e_q, w_acc_base, w_rnd, w_shr;
  logic signed [DATA_W-1:0] w_y;

  // MAC datapath: the k=1 step seeds the accumulator with the scaled residual
  // instead of the running sum.
  always_comb begin
    w_hidx     = r_k - 1'b1;
    w_h        = r_hist[w_hidx];
    w_prod     = $signed(bus.a_rdata) * w_h;
    w_prod_x   = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
    w_e_q      = {{(ACC_W-DATA_W-COEF_FRAC){bus.e_rdata[DATA_W-1]}}, bus.e_rdata, {COEF_FRAC{1'b0}}};
    w_acc_base = (r_k == AAW'(1)) ? w_e_q : r_acc;
  end

  // Round half up, arithmetic shift back to integer, clamp to DATA_W.
  always_comb begin
    w_rnd = r_acc + RND;
    w_shr = w_rnd >>> COEF_FRAC;
    if (w_shr > SAT_MAX)      w_y = SAT_MAX[DATA_W-1:0];
    else if (w_shr < SAT_MIN) w_y = SAT_MIN[DATA_W-1:0];
    else                      w_y = w_shr[DATA_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.ready    = 1'b0;
    bus.a_raddr  = '0;
    bus.e_raddr  = '0;
    bus.y_waddr  = '0;
    bus.y_wdata  = '0;
    bus.y_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) w_next = S_FETCH;
      end
      S_FETCH: begin
        bus.e_raddr = r_n;
        bus.a_raddr = AAW'(1);
        w_next      = S_MAC;
      end
      S_MAC: begin
        // prefetch a[k+1]; park at 0 after the last tap
        bus.a_raddr = (r_k < AAW'(ORDER)) ? r_k + 1'b1 : '0;
        if (r_k == AAW'(ORDER)) w_next = S_WRITE;
      end
      S_WRITE: begin
        bus.y_we    = 1'b1;
        bus.y_waddr = r_n;
        bus.y_wdata = w_y;
        w_next      = (r_n == EAW'(FRAME_LEN - 1)) ? S_IDLE : S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_n   <= '0;
      r_k   <= '0;
      r_acc <= '0;
      for (int i = 0; i < ORDER; i++) r_hist[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_n <= '0;
          if (bus.start && bus.clear_state)
            for (int i = 0; i < ORDER; i++) r_hist[i] <= '0;
        end
        S_FETCH: r_k <= AAW'(1);
        S_MAC: begin
          r_acc <= w_acc_base - w_prod_x;
          r_k   <= r_k + 1'b1;
        end
        S_WRITE: begin
          for (int i = ORDER - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
          r_hist[0] <= w_y;
          r_n       <= r_n + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
